// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : PC register and IF/ID pipeline register with stall and
//               branch/jump redirect for a single-issue MIPS front end.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  input  logic [31:0]      imem_instr,
  output logic [31:0]      imem_addr,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_pc_plus4,
  output logic             ifid_valid,
  output logic             misalign_err,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [31:0] c_align_mask = 32'hFFFF_FFFC;

  logic [31:0]      r_pc;
  logic [31:0]      r_ifid_instr;
  logic [31:0]      r_ifid_pc_plus4;
  logic             r_ifid_valid;
  logic             r_misalign_err;
  logic [CNT_W-1:0] r_fetch_count;

  logic             w_redirect;
  logic [31:0]      w_target;
  logic [31:0]      w_pc_plus4;

  // The branch in EX is older than the jump in ID, so it takes precedence.
  assign w_redirect = branch_taken | jump;
  assign w_target   = branch_taken ? branch_target : jump_target;
  assign w_pc_plus4 = r_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc            <= RESET_PC;
      r_ifid_instr    <= NOP_INSTR;
      r_ifid_pc_plus4 <= 32'd0;
      r_ifid_valid    <= 1'b0;
      r_misalign_err  <= 1'b0;
      r_fetch_count   <= '0;
    end else if (w_redirect) begin
      r_pc            <= w_target & c_align_mask;
      r_ifid_instr    <= NOP_INSTR;
      r_ifid_pc_plus4 <= 32'd0;
      r_ifid_valid    <= 1'b0;
      if (w_target[1:0] != 2'b00) begin
        r_misalign_err <= 1'b1;
      end
    end else if (!stall) begin
      r_pc            <= w_pc_plus4;
      r_ifid_instr    <= imem_instr;
      r_ifid_pc_plus4 <= w_pc_plus4;
      r_ifid_valid    <= 1'b1;
      r_fetch_count   <= r_fetch_count + CNT_W'(1);
    end
  end

  assign imem_addr     = r_pc;
  assign ifid_instr    = r_ifid_instr;
  assign ifid_pc_plus4 = r_ifid_pc_plus4;
  assign ifid_valid    = r_ifid_valid;
  assign misalign_err  = r_misalign_err;
  assign fetch_count   = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Directed scoreboard bench for instruction_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_instr;
  logic [31:0] imem_addr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        misalign_err;
  logic [31:0] fetch_count;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  exp_t q_exp[$];
  int   n_asserts = 0;
  int   n_fails   = 0;

  always #5 clk = ~clk;

  // Instruction memory: word n at byte address 4n holds 32'h1000_0000 + n.
  assign imem_instr = 32'h1000_0000 + (imem_addr >> 2);

  instruction_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_instr    (imem_instr),
    .imem_addr     (imem_addr),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_valid    (ifid_valid),
    .misalign_err  (misalign_err),
    .fetch_count   (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one edge worth of stimulus, queue its expected result, then check.
  task automatic step(input logic rn, input logic st, input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt,
                      input logic [31:0] e_addr, input logic [31:0] e_instr,
                      input logic [31:0] e_pc4, input logic e_valid,
                      input logic e_err, input logic [31:0] e_cnt, input string tag);
    exp_t e;
    exp_t g;
    @(negedge clk);
    rst_n = rn; stall = st; branch_taken = br; branch_target = bt;
    jump = jp; jump_target = jt;
    e.addr = e_addr; e.instr = e_instr; e.pc4 = e_pc4;
    e.valid = e_valid; e.err = e_err; e.cnt = e_cnt;
    q_exp.push_back(e);
    @(posedge clk);
    #1;
    n_asserts++;
    assert (q_exp.size() != 0) else begin
      n_fails++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end
    if (q_exp.size() != 0) begin
      g = q_exp.pop_front();
      chk({tag, ".addr"},  imem_addr,            g.addr);
      chk({tag, ".instr"}, ifid_instr,           g.instr);
      chk({tag, ".pc4"},   ifid_pc_plus4,        g.pc4);
      chk({tag, ".valid"}, {31'd0, ifid_valid},  {31'd0, g.valid});
      chk({tag, ".err"},   {31'd0, misalign_err}, {31'd0, g.err});
      chk({tag, ".cnt"},   fetch_count,          g.cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    jump = 1'b0; jump_target = 32'd0;

    step(0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 0,0, 0, "reset");
    step(1,0,0,0,0,0, 32'h4, 32'h1000_0000, 32'h4, 1,0, 1, "fetch0");
    step(1,0,0,0,0,0, 32'h8, 32'h1000_0001, 32'h8, 1,0, 2, "fetch1");
    step(1,1,0,0,0,0, 32'h8, 32'h1000_0001, 32'h8, 1,0, 2, "stall_a");
    step(1,1,0,0,0,0, 32'h8, 32'h1000_0001, 32'h8, 1,0, 2, "stall_b");
    step(1,0,0,0,0,0, 32'hC, 32'h1000_0002, 32'hC, 1,0, 3, "fetch2");
    step(1,0,0,0,0,0, 32'h10, 32'h1000_0003, 32'h10, 1,0, 4, "fetch3");
    step(1,1,1,32'h40,0,0, 32'h40, 32'h0, 32'h0, 0,0, 4, "br_stall");
    step(1,0,0,0,0,0, 32'h44, 32'h1000_0010, 32'h44, 1,0, 5, "after_br");
    step(1,0,1,32'h80,1,32'hC0, 32'h80, 32'h0, 32'h0, 0,0, 5, "br_vs_jmp");
    step(1,0,0,0,0,0, 32'h84, 32'h1000_0020, 32'h84, 1,0, 6, "after_bj");
    step(1,0,0,0,1,32'h22, 32'h20, 32'h0, 32'h0, 0,1, 6, "jmp_misal");
    step(1,0,0,0,0,0, 32'h24, 32'h1000_0008, 32'h24, 1,1, 7, "err_sticky");
    step(1,0,0,0,1,32'h100, 32'h100, 32'h0, 32'h0, 0,1, 7, "redir_a");
    step(1,0,1,32'h200,0,0, 32'h200, 32'h0, 32'h0, 0,1, 7, "redir_b");
    step(1,0,0,0,0,0, 32'h204, 32'h1000_0080, 32'h204, 1,1, 8, "after_rr");
    step(1,0,0,0,1,32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'h0, 32'h0, 0,1, 8, "jmp_top");
    step(1,0,0,0,0,0, 32'hFFFF_FFFC, 32'h4FFF_FFFE, 32'hFFFF_FFFC, 1,1, 9, "top_m4");
    step(1,0,0,0,0,0, 32'h0, 32'h4FFF_FFFF, 32'h0, 1,1, 10, "wrap");
    step(1,1,0,0,0,0, 32'h0, 32'h4FFF_FFFF, 32'h0, 1,1, 10, "stall_c");
    step(0,1,1,32'h300,0,0, 32'h0, 32'h0, 32'h0, 0,0, 0, "rst_stall");
    step(1,0,0,0,0,0, 32'h4, 32'h1000_0000, 32'h4, 1,0, 1, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Front end of the single-issue MIPS pipeline. Holds the program counter and drives the instruction memory address. Each cycle it registers the returned instruction word into the IF/ID pipeline register. It supports stall from hazard detection and redirect (flush) from branch resolution in EX and jumps decoded in ID.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, word inserted into IF/ID on reset or flush (sll $0,$0,0)
CNT_W, 32, width of the fetched-instruction counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
stall  input  1  hold PC and IF/ID (load-use hazard)
branch_taken  input  1  branch resolved taken in EX
branch_target  input  32  branch destination byte address
jump  input  1  jump decoded in ID
jump_target  input  32  jump destination byte address
imem_instr  input  32  instruction word returned for imem_addr, combinational in the same cycle
imem_addr  output  32  byte address to instruction memory; equals current PC
ifid_instr  output  32  registered instruction
ifid_pc_plus4  output  32  registered PC+4 of ifid_instr
ifid_valid  output  1  ifid_instr is a real fetched instruction, not a bubble
misalign_err  output  1  sticky: a redirect target had nonzero bits [1:0]
fetch_count  output  CNT_W  number of instructions accepted into IF/ID

Behaviour:
- Clock is clk. Reset is synchronous and active-low on rst_n. All state updates on the rising edge of clk only.
- Reset (rst_n=0 at edge): pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc_plus4=0, ifid_valid=0, misalign_err=0, fetch_count=0. Reset overrides every other input. Reset mid-stall or mid-redirect discards that operation.
- imem_addr is driven directly from the pc register with no combinational path from inputs. It is therefore valid from the cycle after the reset edge.
- Priority per edge when rst_n=1: redirect > stall > normal fetch.
- Redirect (branch_taken | jump):
  - Target is branch_target when branch_taken=1, otherwise jump_target. Branch wins over a simultaneous jump because the EX instruction is older.
  - pc <= target & ~32'h3.
  - ifid_instr <= NOP_INSTR, ifid_valid <= 0, ifid_pc_plus4 <= 0. This flushes the wrong-path fetch.
  - fetch_count unchanged.
  - If the selected target has bits[1:0] != 0, misalign_err <= 1. It stays 1 until reset.
  - A redirect asserted together with stall still redirects; stall is ignored for that edge.
- Stall (stall=1, no redirect): pc, ifid_instr, ifid_pc_plus4, ifid_valid and fetch_count all hold.
- Normal:
  - pc <= pc + 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - ifid_instr <= imem_instr; ifid_pc_plus4 <= pc + 4; ifid_valid <= 1.
  - fetch_count <= fetch_count + 1, wrapping modulo 2^CNT_W.
- Fetch latency: the instruction at address A appears on ifid_instr exactly one edge after imem_addr==A with no stall or redirect at that edge.
- Consecutive redirects are each applied. Only the last target survives, and each redirect produces a bubble.
- No X propagation: outputs are fully defined whenever rst_n has been sampled low at least once.

Test Plan:
- Reset then free run; memory holds word n = 32'h1000_0000+n at address 4n → imem_addr 0,4,8,12 on successive cycles; ifid_instr 32'h1000_0000, _0001, _0002 one edge later; ifid_pc_plus4 4,8,12; fetch_count 1,2,3.
- Stall held 2 cycles while pc=8 → imem_addr stays 8, ifid_instr stays 32'h1000_0001, fetch_count stays 2. After release, next ifid_instr = 32'h1000_0002.
- branch_taken=1, branch_target=32'h40 with stall=1, while pc=16 → next edge imem_addr=32'h40, ifid_valid=0, ifid_instr=0, fetch_count unchanged. The following edge gives ifid_instr = word at 32'h40 (32'h1000_0010), ifid_valid=1.
- branch_taken=1 (target 32'h80) and jump=1 (target 32'hC0) on the same edge → imem_addr=32'h80.
- jump=1, jump_target=32'h22 → imem_addr=32'h20, misalign_err=1. It remains 1 across later fetches and clears only after rst_n=0 for one edge.
- Force pc near the top via jump_target=32'hFFFF_FFF8, then run 2 cycles → imem_addr FFFF_FFFC, then 0. Assert rst_n=0 during a stall → pc=RESET_PC and ifid_valid=0 at that edge.
